// File: rtl/c1908d_seq_pkg.sv
// Shared types and constants for the c1908d vector sequencer and lockstep checker.
package c1908d_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

  // One c1908d copy: 33 primary inputs, 25 primary outputs.
  localparam int C1908D_IN_HALF  = 33;
  localparam int C1908D_OUT_HALF = 25;

  // Input vector slices: copy 1 on top (N11..N1104), copy 2 below (N21..N2104).
  localparam int COPY1_IN_HI = 2 * C1908D_IN_HALF - 1;
  localparam int COPY1_IN_LO = C1908D_IN_HALF;
  localparam int COPY2_IN_HI = C1908D_IN_HALF - 1;
  localparam int COPY2_IN_LO = 0;

  // Output bus slices: copy 1 on top (N12753..N12899, MSB first), copy 2 below.
  localparam int COPY1_OUT_HI = 2 * C1908D_OUT_HALF - 1;
  localparam int COPY1_OUT_LO = C1908D_OUT_HALF;
  localparam int COPY2_OUT_HI = C1908D_OUT_HALF - 1;
  localparam int COPY2_OUT_LO = 0;

endpackage

// File: rtl/c1908d_vector_sequencer_lockstep_cmp.sv
// Lockstep comparator: bitwise difference of the two c1908d copies' outputs.
module c1908d_lockstep_cmp
  import c1908d_seq_pkg::*;
(
  input  logic [COPY1_OUT_HI:0]    out_bus,
  output logic [C1908D_OUT_HALF-1:0] diff,
  output logic                     mismatch
);

  // Any differing output bit between copy 1 and copy 2 flags a lockstep mismatch.
  always_comb begin
    diff     = out_bus[COPY1_OUT_HI:COPY1_OUT_LO] ^ out_bus[COPY2_OUT_HI:COPY2_OUT_LO];
    mismatch = |diff;
  end

endmodule

// File: rtl/c1908d_vector_sequencer.sv
// Feeds vectors to the duplicated c1908d DUT, waits for settling, captures and
// lockstep-compares the two copies, and reports each capture on a result stream.
module c1908d_vector_sequencer
  import c1908d_seq_pkg::*;
#(
  parameter int VEC_WIDTH     = 2 * C1908D_IN_HALF,
  parameter int OUT_WIDTH     = 2 * C1908D_OUT_HALF,
  parameter int SETTLE_CYCLES = 2,
  parameter int VEC_LENGTH    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [VEC_WIDTH-1:0]   in_vec,
  output logic                   in_ready,
  output logic [VEC_WIDTH-1:0]   dut_vec,
  input  logic [OUT_WIDTH-1:0]   dut_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OUT_WIDTH-1:0]   res_data,
  output logic [OUT_WIDTH/2-1:0] res_diff,
  output logic                   res_mismatch,
  output logic [CNT_WIDTH-1:0]   vec_cnt,
  output logic [CNT_WIDTH-1:0]   err_cnt,
  output logic                   busy,
  output logic                   done
);

  // Settle counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]     SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_VEC    = CNT_WIDTH'(VEC_LENGTH);

  seq_state_t state_q, state_d;
  logic [SET_W-1:0]     settle_cnt;
  logic [OUT_WIDTH/2-1:0] cmp_diff;
  logic                 cmp_mismatch;
  logic                 accept;
  logic                 capture;
  logic                 run_start;

  c1908d_lockstep_cmp u_cmp (
    .out_bus  (dut_out),
    .diff     (cmp_diff),
    .mismatch (cmp_mismatch)
  );

  // Status and handshake outputs are pure decodes of the state register.
  assign in_ready  = (state_q == ST_LOAD);
  assign res_valid = (state_q == ST_REPORT);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);

  assign accept    = in_valid && in_ready;
  assign capture   = (state_q == ST_SETTLE) && (settle_cnt == '0);
  assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start)     state_d = ST_LOAD;
      ST_LOAD:   if (in_valid)  state_d = ST_SETTLE;
      ST_SETTLE: if (capture)   state_d = ST_REPORT;
      ST_REPORT: if (res_ready) state_d = (vec_cnt == LAST_VEC) ? ST_DONE : ST_LOAD;
      ST_DONE:   if (start)     state_d = ST_LOAD;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Settle counter: loaded on vector acceptance, counts down while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       settle_cnt <= '0;
    else if (accept)                  settle_cnt <= SETTLE_LOAD;
    else if ((state_q == ST_SETTLE) && !capture) settle_cnt <= settle_cnt - 1'b1;
  end

  // Vector register: only an accepted vector changes what the DUT sees.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are flops, not RAM, so they take the async reset and come up as zero.
    if (!rst_n)      dut_vec <= '0;
    else if (accept) dut_vec <= in_vec;
  end

  // Result capture: held from capture until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data     <= '0;
      res_diff     <= '0;
      res_mismatch <= 1'b0;
    end else if (capture) begin
      res_data     <= dut_out;
      res_diff     <= cmp_diff;
      res_mismatch <= cmp_mismatch;
    end
  end

  // Run statistics: cleared on an accepted start, bumped on each capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt <= '0;
      err_cnt <= '0;
    end else if (run_start) begin
      vec_cnt <= '0;
      err_cnt <= '0;
    end else if (capture) begin
      vec_cnt <= vec_cnt + CNT_WIDTH'(1);
      if (cmp_mismatch) err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
  end

  // Mismatching vectors are a subset of captured vectors.
  a_err_le_vec : assert property (@(posedge clk) disable iff (!rst_n) err_cnt <= vec_cnt);

  // Both DUT copies see a frozen stimulus for the whole settle window.
  a_vec_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_SETTLE) |=> ($stable(dut_vec[COPY1_IN_HI:COPY1_IN_LO]) &&
                                $stable(dut_vec[COPY2_IN_HI:COPY2_IN_LO])));

endmodule

// File: tb/tb_c1908d_vector_sequencer.sv
// Directed bench for the c1908d vector sequencer; the bench plays the DUT's role on dut_out.
module tb_c1908d_vector_sequencer;

  localparam int VW = 66;
  localparam int OW = 50;
  localparam int HW = 25;
  localparam int SETTLE = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [VW-1:0] in_vec;
  logic          in_ready;
  logic [VW-1:0] dut_vec;
  logic [OW-1:0] dut_out;
  logic          res_valid;
  logic          res_ready;
  logic [OW-1:0] res_data;
  logic [HW-1:0] res_diff;
  logic          res_mismatch;
  logic [CW-1:0] vec_cnt;
  logic [CW-1:0] err_cnt;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  c1908d_vector_sequencer #(
    .VEC_WIDTH(VW), .OUT_WIDTH(OW), .SETTLE_CYCLES(SETTLE), .VEC_LENGTH(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready), .dut_vec(dut_vec), .dut_out(dut_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_diff(res_diff),
    .res_mismatch(res_mismatch), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector, wait for capture, optionally stall the result stream, then drain it.
  task automatic send_vec(input string tag, input logic [VW-1:0] vec, input logic [OW-1:0] outv,
                          input logic [HW-1:0] exp_diff, input logic exp_mm,
                          input int exp_vc, input int exp_ec, input int hold);
    int waited;
    int lat;
    in_vec   = vec;
    in_valid = 1'b1;
    dut_out  = outv;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    tick();  // acceptance edge
    in_valid = 1'b0;
    check({tag, "_dut_vec"}, 128'(dut_vec), 128'(vec));
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(SETTLE));
    check({tag, "_res_data"}, 128'(res_data), 128'(outv));
    check({tag, "_res_diff"}, 128'(res_diff), 128'(exp_diff));
    check({tag, "_res_mm"}, 128'(res_mismatch), 128'(exp_mm));
    check({tag, "_vec_cnt"}, 128'(vec_cnt), 128'(exp_vc));
    check({tag, "_err_cnt"}, 128'(err_cnt), 128'(exp_ec));
    if (hold > 0) begin
      // Source offers a new vector and the DUT outputs wander while results are stalled.
      in_valid = 1'b1;
      in_vec   = ~vec;
      dut_out  = ~outv;
      for (int i = 0; i < hold; i++) begin
        tick();
        check({tag, "_bp_valid"}, 128'(res_valid), 128'(1));
        check({tag, "_bp_data"}, 128'(res_data), 128'(outv));
        check({tag, "_bp_in_ready"}, 128'(in_ready), 128'(0));
        check({tag, "_bp_dut_vec"}, 128'(dut_vec), 128'(vec));
      end
    end
    res_ready = 1'b1;
    tick();  // handshake edge
    res_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_res_valid_drop"}, 128'(res_valid), 128'(0));
    check({tag, "_no_consume"}, 128'(dut_vec), 128'(vec));
  endtask

  localparam logic [VW-1:0] V1 = 66'h1_0123_4567_89AB_CDEF;
  localparam logic [VW-1:0] V2 = 66'h2_FEDC_BA98_7654_3210;
  localparam logic [VW-1:0] V3 = 66'h3_AAAA_5555_0F0F_F0F0;
  localparam logic [VW-1:0] V4 = 66'h0_0000_0001_0000_0001;
  localparam logic [OW-1:0] O_MATCH_A = {25'h0ABCDEF, 25'h0ABCDEF};
  localparam logic [OW-1:0] O_MATCH_B = {25'h1555555, 25'h1555555};
  localparam logic [OW-1:0] O_MISS    = {25'h1FFFFFF, 25'h1FFFFFE};

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = '0;
    dut_out = '0; res_ready = 1'b0;
    tick();
    check("rst_dut_vec", 128'(dut_vec), 128'(0));
    check("rst_res_valid", 128'(res_valid), 128'(0));
    check("rst_flags", 128'({busy, done, in_ready, res_mismatch}), 128'(0));
    check("rst_cnts", 128'({vec_cnt, err_cnt}), 128'(0));
    check("rst_res", 128'({res_data, res_diff}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Start from IDLE; then the source stalls for 5 cycles in LOAD.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_idle_busy", 128'({busy, in_ready, done}), 128'(3'b110));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_in_ready", 128'(in_ready), 128'(1));
      check("stall_dut_vec", 128'(dut_vec), 128'(0));
    end

    // Vector 1 matches; start pulsed during settle is ignored; 3-cycle backpressure.
    in_vec = V1; in_valid = 1'b1; dut_out = O_MATCH_A;
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", 128'({busy, vec_cnt}), 128'({1'b1, 16'd0}));
    tick();
    check("v1_res_valid", 128'(res_valid), 128'(1));
    check("v1_res_data", 128'(res_data), 128'(O_MATCH_A));
    check("v1_cnts", 128'({vec_cnt, err_cnt}), 128'({16'd1, 16'd0}));
    in_valid = 1'b1; in_vec = V2; dut_out = O_MISS;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("v1_bp_valid", 128'(res_valid), 128'(1));
      check("v1_bp_data", 128'(res_data), 128'(O_MATCH_A));
      check("v1_bp_in_ready", 128'(in_ready), 128'(0));
      check("v1_bp_dut_vec", 128'(dut_vec), 128'(V1));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("v1_after_hs", 128'({res_valid, in_ready}), 128'(2'b01));
    check("v1_after_hs_vec", 128'(dut_vec), 128'(V1));

    // Vector 2 (pending since backpressure) mismatches in bit 0.
    send_vec("v2", V2, O_MISS, 25'h0000001, 1'b1, 2, 1, 0);
    send_vec("v3", V3, O_MATCH_B, 25'h0, 1'b0, 3, 1, 2);
    send_vec("v4", V4, O_MATCH_A, 25'h0, 1'b0, 4, 1, 0);
    check("run1_done", 128'({done, busy}), 128'(2'b10));
    check("run1_cnts", 128'({vec_cnt, err_cnt}), 128'({16'd4, 16'd1}));
    tick();
    check("done_holds_vec", 128'(dut_vec), 128'(V4));
    check("done_holds_res", 128'(res_data), 128'(O_MATCH_A));

    // Restart from DONE: counters clear, LOAD entered on the next edge, results kept.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_state", 128'({in_ready, busy, done}), 128'(3'b110));
    check("restart_cnts", 128'({vec_cnt, err_cnt}), 128'(0));
    check("restart_res_kept", 128'(res_data), 128'(O_MATCH_A));

    // Clean run: all halves match.
    send_vec("r2v1", V4, O_MATCH_B, 25'h0, 1'b0, 1, 0, 0);
    send_vec("r2v2", V3, O_MATCH_A, 25'h0, 1'b0, 2, 0, 0);
    send_vec("r2v3", V2, O_MATCH_B, 25'h0, 1'b0, 3, 0, 0);
    send_vec("r2v4", V1, O_MATCH_A, 25'h0, 1'b0, 4, 0, 0);
    check("run2_done", 128'({done, vec_cnt, err_cnt}), 128'({1'b1, 16'd4, 16'd0}));

    // Reset mid-SETTLE aborts the run and nothing is captured afterwards.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_vec = V3; in_valid = 1'b1; dut_out = O_MISS;
    tick();
    in_valid = 1'b0;
    check("pre_rst_settle", 128'({busy, in_ready, res_valid}), 128'(3'b100));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vec", 128'(dut_vec), 128'(0));
    check("mid_rst_flags", 128'({busy, done, res_valid, in_ready}), 128'(0));
    check("mid_rst_cnts", 128'({vec_cnt, err_cnt}), 128'(0));
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", 128'({busy, res_valid, in_ready, vec_cnt}), 128'(0));
      check("post_rst_res", 128'(res_data), 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
